// File: rtl/seg_scan_capture.sv
// ---------------------------------------------------------------------------
// seg_scan_capture
// Receiver for the multiplexed 7-segment scan bus of digital_clock. Samples the
// segment/select lines, waits for each digit to settle, decodes it back to BCD
// and reassembles a HH:MM frame. A frame is committed only when it arrives in
// order (min units, min tens, hr units, hr tens) with legal digits.
//
// Parameters
//   SETTLE_CYCLES   consecutive identical samples needed to accept a digit
//                   (max 65535)
//   TIMEOUT_CYCLES  cycles without a select change before the link is lost
//
// Ports
//   sys_clk      in   system clock
//   sys_rst_n    in   asynchronous active-low reset
//   seg_in[6:0]  in   segment lines, bit0=A .. bit6=G
//   sel_in[3:0]  in   one-hot digit select (0:min units .. 3:hr tens)
//   hrs_1/hrs_0  out  hour tens / units BCD
//   min_1/min_0  out  minute tens / units BCD
//   frame_valid  out  1-cycle pulse, new frame loaded onto the BCD outputs
//   frame_err    out  1-cycle pulse, frame discarded
//   sig_lost     out  level, no select activity for TIMEOUT_CYCLES
//
// Build option
//   SEG_ACTIVE_LOW_EN  invert synchronised seg/sel (common-anode wiring)
// ---------------------------------------------------------------------------
module seg_scan_capture #(
  parameter logic [25:0] SETTLE_CYCLES  = 26'd16,
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd108000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [6:0] seg_in,
  input  logic [3:0] sel_in,
  output logic [3:0] hrs_1,
  output logic [3:0] hrs_0,
  output logic [3:0] min_1,
  output logic [3:0] min_0,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       sig_lost
);

  localparam int unsigned SEG_W = 7;
  localparam int unsigned SEL_W = 4;
  localparam int unsigned BCD_W = 4;
  localparam int unsigned SET_W = 16;
  localparam int unsigned TO_W  = 26;
  localparam int unsigned SMP_W = SEL_W + SEG_W;

  localparam logic [SET_W-1:0] SET_MAX  = '1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 26'd1);
  localparam logic [TO_W-1:0]  TO_MAX   = '1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 26'd1);

  localparam logic [SEL_W-1:0] SEL_MIN0 = 4'b0001;
  localparam logic [SEL_W-1:0] SEL_MIN1 = 4'b0010;
  localparam logic [SEL_W-1:0] SEL_HRS0 = 4'b0100;
  localparam logic [SEL_W-1:0] SEL_HRS1 = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_RST  = 4'b1111;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_CAP1 = 2'd1,
    S_CAP2 = 2'd2,
    S_CAP3 = 2'd3
  } state_t;

  // Segment pattern -> {valid, bcd}
  function automatic logic [BCD_W:0] f_decode(input logic [SEG_W-1:0] s);
    logic [BCD_W:0] d;
    d = '0;
    case (s)
      7'h3F:   d = {1'b1, 4'd0};
      7'h06:   d = {1'b1, 4'd1};
      7'h5B:   d = {1'b1, 4'd2};
      7'h4F:   d = {1'b1, 4'd3};
      7'h66:   d = {1'b1, 4'd4};
      7'h6D:   d = {1'b1, 4'd5};
      7'h7D:   d = {1'b1, 4'd6};
      7'h07:   d = {1'b1, 4'd7};
      7'h7F:   d = {1'b1, 4'd8};
      7'h6F:   d = {1'b1, 4'd9};
      default: d = '0;
    endcase
    return d;
  endfunction

  // -------------------------------------------------------------------------
  // Input synchroniser
  // -------------------------------------------------------------------------
  logic [SEG_W-1:0] r_seg_s1, r_seg_s2;
  logic [SEL_W-1:0] r_sel_s1, r_sel_s2;
  logic [SEG_W-1:0] w_seg;
  logic [SEL_W-1:0] w_sel;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_seg_s1 <= '0;
      r_seg_s2 <= '0;
      r_sel_s1 <= '0;
      r_sel_s2 <= '0;
    end else begin
      r_seg_s1 <= seg_in;
      r_seg_s2 <= r_seg_s1;
      r_sel_s1 <= sel_in;
      r_sel_s2 <= r_sel_s1;
    end
  end

`ifdef SEG_ACTIVE_LOW_EN
  assign w_seg = ~r_seg_s2;
  assign w_sel = ~r_sel_s2;
`else
  assign w_seg = r_seg_s2;
  assign w_sel = r_sel_s2;
`endif

  // -------------------------------------------------------------------------
  // Settle and link-timeout counters
  // -------------------------------------------------------------------------
  logic [SMP_W-1:0] w_cur;
  logic [SMP_W-1:0] r_prev;
  logic [SET_W-1:0] r_settle;
  logic [TO_W-1:0]  r_to;
  logic             w_same;
  logic             w_sel_chg;
  logic             w_accept;
  logic             w_timeout;

  assign w_cur     = {w_sel, w_seg};
  assign w_same    = (w_cur == r_prev);
  assign w_sel_chg = (w_sel != r_prev[SMP_W-1:SEG_W]);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_prev   <= '0;
      r_settle <= '0;
      r_to     <= '0;
    end else begin
      r_prev <= w_cur;
      if (!w_same) begin
        r_settle <= '0;
      end else if (r_settle != SET_MAX) begin
        r_settle <= r_settle + SET_W'(1);
      end
      if (w_sel_chg) begin
        r_to <= '0;
      end else if (r_to != TO_MAX) begin
        r_to <= r_to + TO_W'(1);
      end
    end
  end

  // The count passes SET_LAST exactly once per dwell, so accept fires once;
  // r_prev still holds the settled sample during that cycle.
  assign w_accept  = (r_settle == SET_LAST);
  assign w_timeout = (r_to == TO_LAST);

  logic [SEL_W-1:0] w_acc_sel;
  logic [BCD_W:0]   w_dec;
  logic [BCD_W-1:0] w_dec_bcd;
  logic             w_dec_ok;
  logic             w_acc_onehot;

  assign w_acc_sel    = r_prev[SMP_W-1:SEG_W];
  assign w_dec        = f_decode(r_prev[SEG_W-1:0]);
  assign w_dec_bcd    = w_dec[BCD_W-1:0];
  assign w_dec_ok     = w_dec[BCD_W];
  assign w_acc_onehot = $onehot(w_acc_sel);

  // -------------------------------------------------------------------------
  // Frame assembly FSM
  // -------------------------------------------------------------------------
  state_t           r_state, w_state_nxt;
  logic [BCD_W-1:0] r_dig0, r_dig1, r_dig2;
  logic [BCD_W-1:0] w_dig0, w_dig1, w_dig2;
  logic [2:0]       r_dv, w_dv;
  logic [BCD_W-1:0] r_hrs_1, r_hrs_0, r_min_1, r_min_0;
  logic [BCD_W-1:0] w_hrs_1, w_hrs_0, w_min_1, w_min_0;
  logic             r_fv, r_fe, r_lost;
  logic             w_fv, w_fe, w_lost;
  logic             w_ooo;
  logic             w_good;

  // Legal HH:MM check using the stored digits plus the hr-tens digit in flight
  assign w_good = (&r_dv) && w_dec_ok &&
                  (r_dig1 <= 4'd5) &&
                  (w_dec_bcd <= 4'd2) &&
                  ((w_dec_bcd != 4'd2) || (r_dig2 <= 4'd3));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_HUNT;
      r_dig0  <= '0;
      r_dig1  <= '0;
      r_dig2  <= '0;
      r_dv    <= '0;
      r_hrs_1 <= '0;
      r_hrs_0 <= '0;
      r_min_1 <= '0;
      r_min_0 <= '0;
      r_fv    <= 1'b0;
      r_fe    <= 1'b0;
      r_lost  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_dig0  <= w_dig0;
      r_dig1  <= w_dig1;
      r_dig2  <= w_dig2;
      r_dv    <= w_dv;
      r_hrs_1 <= w_hrs_1;
      r_hrs_0 <= w_hrs_0;
      r_min_1 <= w_min_1;
      r_min_0 <= w_min_0;
      r_fv    <= w_fv;
      r_fe    <= w_fe;
      r_lost  <= w_lost;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dig0      = r_dig0;
    w_dig1      = r_dig1;
    w_dig2      = r_dig2;
    w_dv        = r_dv;
    w_hrs_1     = r_hrs_1;
    w_hrs_0     = r_hrs_0;
    w_min_1     = r_min_1;
    w_min_0     = r_min_0;
    w_fv        = 1'b0;
    w_fe        = 1'b0;
    w_lost      = r_lost;
    w_ooo       = 1'b0;

    if (w_timeout) begin
      // Link loss drops any partial frame silently
      w_state_nxt = S_HUNT;
      w_lost      = 1'b1;
    end else if (w_accept) begin
      if (!w_acc_onehot) begin
        // Blank or multi-hot select; all-ones means the source is in reset
        if (r_state != S_HUNT) begin
          w_state_nxt = S_HUNT;
          w_fe        = (w_acc_sel != SEL_RST);
        end
      end else begin
        case (r_state)
          S_HUNT: begin
            if (w_acc_sel == SEL_MIN0) begin
              w_dig0      = w_dec_bcd;
              w_dv[0]     = w_dec_ok;
              w_state_nxt = S_CAP1;
            end
          end
          S_CAP1: begin
            if (w_acc_sel == SEL_MIN1) begin
              w_dig1      = w_dec_bcd;
              w_dv[1]     = w_dec_ok;
              w_state_nxt = S_CAP2;
            end else begin
              w_ooo = 1'b1;
            end
          end
          S_CAP2: begin
            if (w_acc_sel == SEL_HRS0) begin
              w_dig2      = w_dec_bcd;
              w_dv[2]     = w_dec_ok;
              w_state_nxt = S_CAP3;
            end else begin
              w_ooo = 1'b1;
            end
          end
          S_CAP3: begin
            if (w_acc_sel == SEL_HRS1) begin
              w_state_nxt = S_HUNT;
              if (w_good) begin
                w_hrs_1 = w_dec_bcd;
                w_hrs_0 = r_dig2;
                w_min_1 = r_dig1;
                w_min_0 = r_dig0;
                w_fv    = 1'b1;
                w_lost  = 1'b0;
              end else begin
                w_fe = 1'b1;
              end
            end else begin
              w_ooo = 1'b1;
            end
          end
          default: w_state_nxt = S_HUNT;
        endcase

        // Out-of-order digit: a fresh min-units digit restarts the frame
        if (w_ooo) begin
          w_fe = 1'b1;
          if (w_acc_sel == SEL_MIN0) begin
            w_dig0      = w_dec_bcd;
            w_dv[0]     = w_dec_ok;
            w_state_nxt = S_CAP1;
          end else begin
            w_state_nxt = S_HUNT;
          end
        end
      end
    end
  end

  assign hrs_1       = r_hrs_1;
  assign hrs_0       = r_hrs_0;
  assign min_1       = r_min_1;
  assign min_0       = r_min_0;
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;
  assign sig_lost    = r_lost;

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

  localparam int DWELL = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] sel_in;
  logic [3:0] hrs_1, hrs_0, min_1, min_0;
  logic       frame_valid, frame_err, sig_lost;

  always #5 clk = ~clk;

  seg_scan_capture #(
    .SETTLE_CYCLES (26'd4),
    .TIMEOUT_CYCLES(26'd64)
  ) dut (
    .sys_clk    (clk),
    .sys_rst_n  (rst_n),
    .seg_in     (seg_in),
    .sel_in     (sel_in),
    .hrs_1      (hrs_1),
    .hrs_0      (hrs_0),
    .min_1      (min_1),
    .min_0      (min_0),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .sig_lost   (sig_lost)
  );

  // Pulse counters, written only here
  int fv_total   = 0;
  int fe_total   = 0;
  int both_total = 0;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_total++;
    if (frame_err === 1'b1) fe_total++;
    if (frame_valid === 1'b1 && frame_err === 1'b1) both_total++;
  end

  int n_vec = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0][3:0] sel;   // [0] = first digit scanned
    logic [3:0][6:0] seg;
    int              exp_fv;
    int              exp_fe;
    logic [3:0]      h1, h0, m1, m0;
  } vec_t;

  localparam logic [3:0][3:0] ORD = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [3:0][3:0] OOO = {4'b1000, 4'b0010, 4'b0100, 4'b0001};

  function automatic vec_t mk(input logic [3:0][3:0] sel, input logic [3:0][6:0] seg,
                              input int fv, input int fe,
                              input logic [3:0] h1, input logic [3:0] h0,
                              input logic [3:0] m1, input logic [3:0] m0);
    vec_t v;
    v.sel = sel; v.seg = seg; v.exp_fv = fv; v.exp_fe = fe;
    v.h1 = h1; v.h0 = h0; v.m1 = m1; v.m0 = m0;
    return v;
  endfunction

  task automatic drive_digit(input logic [3:0] sel, input logic [6:0] seg, input int n);
    @(negedge clk);
    sel_in = sel;
    seg_in = seg;
    repeat (n - 1) @(negedge clk);
  endtask

  // Scan one frame and report how many pulses it produced
  task automatic scan_frame(input logic [3:0][3:0] sel, input logic [3:0][6:0] seg,
                            output int dfv, output int dfe);
    int fv0, fe0;
    fv0 = fv_total;
    fe0 = fe_total;
    for (int d = 0; d < 4; d++) drive_digit(sel[d], seg[d], DWELL);
    #1;
    dfv = fv_total - fv0;
    dfe = fe_total - fe0;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] h1, input logic [3:0] h0,
                            input logic [3:0] m1, input logic [3:0] m0);
    check({tag, "_hrs_1"}, 32'(hrs_1), 32'(h1));
    check({tag, "_hrs_0"}, 32'(hrs_0), 32'(h0));
    check({tag, "_min_1"}, 32'(min_1), 32'(m1));
    check({tag, "_min_0"}, 32'(min_0), 32'(m0));
  endtask

  vec_t vecs[11];

  initial begin
    int dfv, dfe, fe0, lat;
    string tag;

    // Segments listed hr tens, hr units, min tens, min units
    vecs[0]  = mk(ORD, {7'h06, 7'h5B, 7'h4F, 7'h66}, 1, 0, 1, 2, 3, 4); // 12:34
    vecs[1]  = mk(ORD, {7'h5B, 7'h4F, 7'h6D, 7'h7B}, 0, 1, 1, 2, 3, 4); // bad min units
    vecs[2]  = mk(ORD, {7'h5B, 7'h6D, 7'h3F, 7'h3F}, 0, 1, 1, 2, 3, 4); // 25:00
    vecs[3]  = mk(ORD, {7'h5B, 7'h4F, 7'h6D, 7'h6F}, 1, 0, 2, 3, 5, 9); // 23:59
    vecs[4]  = mk(ORD, {7'h5B, 7'h66, 7'h3F, 7'h3F}, 0, 1, 2, 3, 5, 9); // 24:00
    vecs[5]  = mk(ORD, {7'h06, 7'h6F, 7'h6D, 7'h6F}, 1, 0, 1, 9, 5, 9); // 19:59
    vecs[6]  = mk(ORD, {7'h06, 7'h6D, 7'h7D, 7'h3F}, 0, 1, 1, 9, 5, 9); // 15:60
    vecs[7]  = mk(ORD, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, 1, 0, 0, 0, 0, 0); // 00:00
    vecs[8]  = mk(ORD, {7'h5B, 7'h3F, 7'h4F, 7'h07}, 1, 0, 2, 0, 3, 7); // 20:37
    vecs[9]  = mk(OOO, {7'h06, 7'h06, 7'h06, 7'h06}, 0, 1, 2, 0, 3, 7); // out of order
    vecs[10] = mk(ORD, {7'h06, 7'h5B, 7'h4F, 7'h66}, 1, 0, 1, 2, 3, 4); // 12:34

    // Reset with the source also in reset (all selects on)
    rst_n  = 1'b0;
    sel_in = 4'b1111;
    seg_in = 7'h00;
    repeat (3) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0);
    check("reset_frame_valid", 32'(frame_valid), 0);
    check("reset_frame_err", 32'(frame_err), 0);
    check("reset_sig_lost", 32'(sig_lost), 1);
    rst_n = 1'b1;
    repeat (DWELL) @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      scan_frame(vecs[i].sel, vecs[i].seg, dfv, dfe);
      check({tag, "_valid_pulses"}, 32'(dfv), 32'(vecs[i].exp_fv));
      check({tag, "_err_pulses"}, 32'(dfe), 32'(vecs[i].exp_fe));
      check_outs(tag, vecs[i].h1, vecs[i].h0, vecs[i].m1, vecs[i].m0);
      check({tag, "_sig_lost"}, 32'(sig_lost), 0);
    end

    // Select frozen mid-frame: link lost, no frame error
    fe0 = fe_total;
    drive_digit(4'b0001, 7'h3F, DWELL);
    @(negedge clk);
    sel_in = 4'b0010;
    seg_in = 7'h3F;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (sig_lost === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("lost_rises_near_timeout", 32'(lat >= 60 && lat <= 70), 1);
    repeat (80 - lat) @(negedge clk);
    #1;
    check("lost_no_frame_err", 32'(fe_total - fe0), 0);
    check("lost_still_set", 32'(sig_lost), 1);
    check_outs("lost_hold", 1, 2, 3, 4);
    scan_frame(ORD, {7'h5B, 7'h4F, 7'h6D, 7'h6F}, dfv, dfe);
    check("recover_valid_pulses", 32'(dfv), 1);
    check("recover_sig_lost", 32'(sig_lost), 0);
    check_outs("recover", 2, 3, 5, 9);

    // Source reset (1111) mid-frame aborts silently
    fe0 = fe_total;
    drive_digit(4'b0001, 7'h3F, DWELL);
    drive_digit(4'b0010, 7'h3F, DWELL);
    drive_digit(4'b1111, 7'h7F, DWELL);
    #1;
    check("src_reset_no_err", 32'(fe_total - fe0), 0);
    scan_frame(ORD, {7'h3F, 7'h3F, 7'h3F, 7'h3F}, dfv, dfe);
    check("src_reset_then_valid", 32'(dfv), 1);
    check("src_reset_then_err", 32'(dfe), 0);
    check_outs("src_reset_frame", 0, 0, 0, 0);

    // Local reset in the middle of a frame
    scan_frame(ORD, {7'h5B, 7'h3F, 7'h4F, 7'h07}, dfv, dfe);
    check("pre_reset_valid", 32'(dfv), 1);
    check_outs("pre_reset", 2, 0, 3, 7);
    drive_digit(4'b0001, 7'h06, DWELL);
    drive_digit(4'b0010, 7'h06, 5);
    rst_n = 1'b0;
    #1;
    check_outs("mid_reset", 0, 0, 0, 0);
    check("mid_reset_sig_lost", 32'(sig_lost), 1);
    check("mid_reset_frame_valid", 32'(frame_valid), 0);
    check("mid_reset_frame_err", 32'(frame_err), 0);

    check("valid_err_same_cycle", 32'(both_total), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
